// File: rtl/pc_fetch_sequencer_if.sv
// Fetch sequencer bus: imem fetch handshake, instruction issue to the
// datapath, and resolution coming back from the datapath.
//   master : the sequencer (drives imem_req/addr, if_* outputs)
//   slave  : imem + datapath side (drives ack/rdata, ready, res_*)
interface pc_fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic        res_valid;
  logic [2:0]  res_npc_op;
  logic        res_zero;
  logic [31:0] res_rs;
  logic        halt_req;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc4,
    input  imem_ack, imem_rdata, if_ready, res_valid, res_npc_op,
           res_zero, res_rs, halt_req
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc4,
    output imem_ack, imem_rdata, if_ready, res_valid, res_npc_op,
           res_zero, res_rs, halt_req
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Multi-cycle fetch / next-PC controller. Owns the architectural PC and runs
// one instruction at a time: FETCH (imem req/ack) -> ISSUE (valid/ready) ->
// RESOLVE (wait res_valid, compute next PC) -> FETCH, or HALT on halt_req.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fetch/issue/resolve bus (master side)
//   halted     : sequencer parked in HALT (left only by reset)
//   retired    : count of resolved instructions (wraps)
//   err_op     : sticky, illegal res_npc_op seen
//   err_align  : sticky, computed next PC was not word aligned
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  pc_fetch_sequencer_if.master      bus,
  output logic                      halted,
  output logic [31:0]               retired,
  output logic                      err_op,
  output logic                      err_align
);

  typedef enum logic [2:0] {
    S_BOOT, S_FETCH, S_ISSUE, S_RESOLVE, S_HALT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, instr_q, retired_q;
  logic        err_op_q, err_align_q;

  logic [31:0] pc4, off, raw_npc, npc;
  logic        op_bad, misalign, resolve;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_BOOT;
    else        state_q <= state_d;
  end

  // Next-state logic; handshakes arriving in the wrong state fall through
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_BOOT:    state_d = S_FETCH;
      S_FETCH:   if (bus.imem_ack) state_d = S_ISSUE;
      S_ISSUE:   if (bus.if_ready) state_d = S_RESOLVE;
      S_RESOLVE: if (bus.res_valid) state_d = bus.halt_req ? S_HALT : S_FETCH;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_BOOT;
    endcase
  end

  // Outputs decoded from the registered state only, so an async reset
  // drops imem_req in the same cycle
  always_comb begin
    bus.imem_req  = (state_q == S_FETCH);
    bus.if_valid  = (state_q == S_ISSUE);
    halted        = (state_q == S_HALT);
    bus.imem_addr = pc_q;
    bus.if_pc     = pc_q;
    bus.if_pc4    = pc4;
    bus.if_instr  = instr_q;
    retired       = retired_q;
    err_op        = err_op_q;
    err_align     = err_align_q;
  end

  // Next-PC computation, all arithmetic modulo 2^32
  always_comb begin
    pc4     = pc_q + 32'd4;
    off     = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    op_bad  = 1'b0;
    raw_npc = pc4;
    case (bus.res_npc_op)
      3'd0: raw_npc = pc4;
      3'd1: raw_npc = bus.res_zero ? (pc4 + off) : pc4;
      3'd2: raw_npc = {pc_q[31:28], instr_q[25:0], 2'b00};
      3'd3: raw_npc = bus.res_rs;
      default: begin
        raw_npc = pc4;
        op_bad  = 1'b1;
      end
    endcase
    // Misaligned targets are forced down to the word boundary and flagged
    misalign = |raw_npc[1:0];
    npc      = {raw_npc[31:2], 2'b00};
    resolve  = (state_q == S_RESOLVE) && bus.res_valid;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      retired_q   <= '0;
      err_op_q    <= 1'b0;
      err_align_q <= 1'b0;
    end else begin
      if (state_q == S_FETCH && bus.imem_ack) instr_q <= bus.imem_rdata;
      if (resolve) begin
        pc_q      <= npc;
        retired_q <= retired_q + 32'd1;
        if (op_bad)   err_op_q    <= 1'b1;
        if (misalign) err_align_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        halted, err_op, err_align;
  logic [31:0] retired;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;

  pc_fetch_sequencer_if bus ();

  pc_fetch_sequencer #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .halted(halted), .retired(retired),
    .err_op(err_op), .err_align(err_align)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic [2:0]  op;
    logic        zero;
    logic [31:0] rs;
    logic        halt;
    int          ack_dly;
    logic [31:0] exp_addr;
    logic [31:0] exp_npc;
    logic        exp_eop;
    logic        exp_eal;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Runs one instruction through FETCH/ISSUE/RESOLVE; samples on negedge,
  // drives inputs right after a negedge.
  task automatic do_instr(input vec_t v, input logic [31:0] exp_ret, output int t_start);
    int n = 0;
    while (!bus.imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("fetch_timeout", 32'(bus.imem_req), 32'd1);
    t_start = cyc;
    chk("imem_addr", bus.imem_addr, v.exp_addr);
    // Delayed ack; stray handshakes in FETCH must be ignored
    for (int d = 0; d < v.ack_dly; d++) begin
      bus.if_ready  = 1'b1;
      bus.res_valid = 1'b1;
      bus.halt_req  = 1'b1;
      @(negedge clk);
      bus.if_ready  = 1'b0;
      bus.res_valid = 1'b0;
      bus.halt_req  = 1'b0;
      chk("req_held", 32'(bus.imem_req), 32'd1);
      chk("addr_stable", bus.imem_addr, v.exp_addr);
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = v.rdata;
    @(negedge clk);
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'hDEAD_BEEF;
    chk("if_valid", 32'(bus.if_valid), 32'd1);
    chk("if_instr", bus.if_instr, v.rdata);
    chk("if_pc4", bus.if_pc4, v.exp_addr + 32'd4);
    bus.if_ready = 1'b1;
    @(negedge clk);
    bus.if_ready   = 1'b0;
    bus.res_valid  = 1'b1;
    bus.res_npc_op = v.op;
    bus.res_zero   = v.zero;
    bus.res_rs     = v.rs;
    bus.halt_req   = v.halt;
    @(negedge clk);
    bus.res_valid  = 1'b0;
    bus.halt_req   = 1'b0;
    chk("next_pc", bus.if_pc, v.exp_npc);
    chk("retired", retired, exp_ret);
    chk("halted", 32'(halted), 32'(v.halt));
    chk("err_op", 32'(err_op), 32'(v.exp_eop));
    chk("err_align", 32'(err_align), 32'(v.exp_eal));
  endtask

  initial begin
    int t0, tprev;
    //         rdata          op   z     rs            h  dly addr          npc           eop   eal
    tbl[0]  = '{32'h0000_0000, 3'd0, 1'b0, 32'h0,        1'b0, 0, 32'h0000_3000, 32'h0000_3004, 1'b0, 1'b0};
    tbl[1]  = '{32'h0000_0001, 3'd0, 1'b0, 32'h0,        1'b0, 0, 32'h0000_3004, 32'h0000_3008, 1'b0, 1'b0};
    tbl[2]  = '{32'h0000_0002, 3'd0, 1'b0, 32'h0,        1'b0, 0, 32'h0000_3008, 32'h0000_300C, 1'b0, 1'b0};
    tbl[3]  = '{32'h0000_0003, 3'd0, 1'b0, 32'h0,        1'b0, 0, 32'h0000_300C, 32'h0000_3010, 1'b0, 1'b0};
    tbl[4]  = '{32'h1000_FFFF, 3'd1, 1'b1, 32'h0,        1'b0, 0, 32'h0000_3010, 32'h0000_3010, 1'b0, 1'b0};
    tbl[5]  = '{32'h1000_FFFF, 3'd1, 1'b0, 32'h0,        1'b0, 0, 32'h0000_3010, 32'h0000_3014, 1'b0, 1'b0};
    tbl[6]  = '{32'h0000_0000, 3'd3, 1'b0, 32'h0000_3000, 1'b0, 0, 32'h0000_3014, 32'h0000_3000, 1'b0, 1'b0};
    tbl[7]  = '{32'h0800_0C40, 3'd2, 1'b0, 32'h0,        1'b0, 0, 32'h0000_3000, 32'h0000_3100, 1'b0, 1'b0};
    tbl[8]  = '{32'h0000_0000, 3'd3, 1'b0, 32'h0000_3005, 1'b0, 0, 32'h0000_3100, 32'h0000_3004, 1'b0, 1'b1};
    tbl[9]  = '{32'h0000_0000, 3'd5, 1'b1, 32'h0000_0001, 1'b0, 0, 32'h0000_3004, 32'h0000_3008, 1'b1, 1'b1};
    tbl[10] = '{32'h1000_0004, 3'd1, 1'b1, 32'h0,        1'b0, 4, 32'h0000_3008, 32'h0000_301C, 1'b1, 1'b1};
    tbl[11] = '{32'h0000_0000, 3'd0, 1'b0, 32'h0,        1'b1, 0, 32'h0000_301C, 32'h0000_3020, 1'b1, 1'b1};

    rst_n          = 1'b0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.if_ready   = 1'b0;
    bus.res_valid  = 1'b0;
    bus.res_npc_op = 3'd0;
    bus.res_zero   = 1'b0;
    bus.res_rs     = 32'h0;
    bus.halt_req   = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(bus.if_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_instr", bus.if_instr, 32'd0);
    chk("rst_pc", bus.if_pc, 32'h3000);
    chk("rst_pc4", bus.if_pc4, 32'h3004);
    chk("rst_errs", {30'd0, err_op, err_align}, 32'd0);

    rst_n = 1'b1;
    chk("boot_no_req", 32'(bus.imem_req), 32'd0);
    @(negedge clk);
    chk("first_req", 32'(bus.imem_req), 32'd1);
    chk("first_addr", bus.imem_addr, 32'h3000);

    tprev = 0;
    for (int i = 0; i < 12; i++) begin
      do_instr(tbl[i], 32'(i + 1), t0);
      if (i == 1 || i == 2) chk("cycles_per_instr", 32'(t0 - tprev), 32'd3);
      tprev = t0;
    end

    // Parked in HALT: stray handshakes ignored, no fetches
    for (int k = 0; k < 4; k++) begin
      bus.imem_ack  = 1'b1;
      bus.if_ready  = 1'b1;
      bus.res_valid = 1'b1;
      @(negedge clk);
      chk("halt_no_req", 32'(bus.imem_req), 32'd0);
      chk("halt_stays", 32'(halted), 32'd1);
    end
    bus.imem_ack  = 1'b0;
    bus.if_ready  = 1'b0;
    bus.res_valid = 1'b0;
    chk("halt_retired", retired, 32'd12);

    // Reset out of HALT, then async reset in the middle of FETCH
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("refetch_req", 32'(bus.imem_req), 32'd1);
    @(negedge clk);
    chk("fetch_wait_req", 32'(bus.imem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_req_drop", 32'(bus.imem_req), 32'd0);
    chk("async_pc", bus.if_pc, 32'h3000);
    chk("async_retired", retired, 32'd0);
    chk("async_errs", {29'd0, halted, err_op, err_align}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_instr(tbl[0], 32'd1, t0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
